// File: rtl/rede_pkg.sv
// Shared constants and types for the rede output collector.
package rede_pkg;

   localparam int NUBITS_D = 31;
   localparam int NUIOOU_D = 4;
   localparam int FDEPTH_D = 2;
   localparam int FCW      = 16;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

endpackage

// File: rtl/rede_out_collector_if.sv
// Host-side word stream of the rede output collector.
interface rede_out_if
   import rede_pkg::*;
#(
   parameter int NUBITS = NUBITS_D,
   parameter int CW     = 2
) ();

   logic [NUBITS-1:0] m_data;
   logic [CW-1:0]     m_chan;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;

   modport master (
      output m_data, m_chan, m_valid, m_last,
      input  m_ready
   );

   modport slave (
      input  m_data, m_chan, m_valid, m_last,
      output m_ready
   );

endinterface

// File: rtl/rede_frame_fifo.sv
// Frame FIFO with pop-before-push when full and a look-ahead head.
module rede_frame_fifo #(
   parameter int W     = 124,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o,
   output logic [W-1:0] head_nxt_o,
   output logic         empty_nxt_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW:0]   wp_q, wp_d;
   logic [AW:0]   rp_q, rp_d;
   logic [AW:0]   cnt, cnt_nxt;
   logic [AW-1:0] rp1;
   logic          push_ok, pop_ok;

   assign cnt     = wp_q - rp_q;
   assign full_o  = (cnt == (AW+1)'(DEPTH));
   assign empty_o = (cnt == '0);
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign wp_d    = wp_q + (AW+1)'(push_ok);
   assign rp_d    = rp_q + (AW+1)'(pop_ok);
   assign rp1     = rp_q[AW-1:0] + AW'(1);
   assign head_o  = mem_q[rp_q[AW-1:0]];
   assign cnt_nxt = cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   assign empty_nxt_o = (cnt_nxt == '0);

   // Head as it will be after this cycle's pop/push settle
   always_comb begin
      head_nxt_o = head_o;
      if (pop_ok) begin
         head_nxt_o = (cnt > (AW+1)'(1)) ? mem_q[rp1] : wdata_i;
      end else if (empty_o) begin
         head_nxt_o = wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wp_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/rede_out_collector.sv
// Collects one-hot strobed processor words into frames and streams them out.
module rede_out_collector
   import rede_pkg::*;
#(
   parameter int NUBITS = NUBITS_D,
   parameter int NUIOOU = NUIOOU_D,
   parameter int FDEPTH = FDEPTH_D,
   parameter int CW     = $clog2(NUIOOU)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUBITS-1:0] io_out,
   input  logic [NUIOOU-1:0] out_en,
   rede_out_if.master        m,
   output logic              ovf,
   output logic              perr,
   input  logic              err_clr,
   output logic [FCW-1:0]    frame_cnt
);

   typedef logic [NUIOOU-1:0][NUBITS-1:0] frame_t;

   localparam logic [CW-1:0] LAST = CW'(NUIOOU-1);

   frame_t            slot_q, slot_d;
   logic [NUIOOU-1:0] mask_q, mask_d, mask_new;
   logic              one_hot, multi, dup, complete;
   logic              ovf_q, ovf_d, perr_q, perr_d;
   logic [FCW-1:0]    fcnt_q, fcnt_d;

   frame_t            head, head_nxt;
   logic              full, empty, empty_nxt;
   logic              pop, push_ok;

   ser_state_e        state_q, state_d;
   logic [CW-1:0]     idx_q, idx_d;
   logic [NUBITS-1:0] data_q, data_d;
   logic              last_q, last_d;

   always_comb begin
      one_hot  = ($countones(out_en) == 1);
      multi    = ($countones(out_en) > 1);
      slot_d   = slot_q;
      mask_new = mask_q;
      if (one_hot) begin
         mask_new = mask_q | out_en;
         for (int k = 0; k < NUIOOU; k++) begin
            if (out_en[k]) slot_d[k] = io_out;
         end
      end
      dup      = one_hot & (|(mask_q & out_en));
      complete = one_hot & (&mask_new);
      mask_d   = complete ? '0 : mask_new;
   end

   // Last word of the head frame leaving frees its slot this cycle
   assign pop     = (state_q == SEND) & m.m_ready & last_q & ~empty;
   assign push_ok = complete & (~full | pop);

   always_comb begin
      ovf_d  = err_clr ? 1'b0 : (ovf_q | (complete & full & ~pop));
      perr_d = err_clr ? 1'b0 : (perr_q | dup | multi);
      fcnt_d = fcnt_q + FCW'(push_ok);
   end

   rede_frame_fifo #(
      .W     (NUIOOU*NUBITS),
      .DEPTH (FDEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (complete),
      .pop_i       (pop),
      .wdata_i     (slot_d),
      .full_o      (full),
      .empty_o     (empty),
      .head_o      (head),
      .head_nxt_o  (head_nxt),
      .empty_nxt_o (empty_nxt)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (!empty_nxt) begin
               state_d = SEND;
               idx_d   = '0;
               data_d  = head_nxt[0];
            end
         end
         SEND: begin
            if (m.m_ready) begin
               if (last_q) begin
                  idx_d = '0;
                  if (!empty_nxt) data_d = head_nxt[0];
                  else state_d = IDLE;
               end else begin
                  idx_d  = idx_q + CW'(1);
                  data_d = head[idx_d];
               end
            end
         end
      endcase
      last_d = (state_d == SEND) && (idx_d == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q  <= '0;
         ovf_q   <= 1'b0;
         perr_q  <= 1'b0;
         fcnt_q  <= '0;
         state_q <= IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         mask_q  <= mask_d;
         ovf_q   <= ovf_d;
         perr_q  <= perr_d;
         fcnt_q  <= fcnt_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      slot_q <= slot_d;
   end

   assign m.m_data   = data_q;
   assign m.m_chan   = idx_q;
   assign m.m_valid  = (state_q == SEND);
   assign m.m_last   = last_q;
   assign ovf        = ovf_q;
   assign perr       = perr_q;
   assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_rede_out_collector.sv
// Directed bench for rede_out_collector.
module tb_rede_out_collector;
   import rede_pkg::*;

   localparam int NB = 31;
   localparam int NO = 4;
   localparam int CW = 2;

   typedef logic [NO-1:0][NB-1:0] fr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          err_clr;
   logic [NB-1:0] io_out;
   logic [NO-1:0] out_en;
   logic          ovf, perr;
   logic [15:0]   frame_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   rede_out_if #(.NUBITS(NB), .CW(CW)) mif ();

   rede_out_collector #(
      .NUBITS (NB),
      .NUIOOU (NO),
      .FDEPTH (2),
      .CW     (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .io_out    (io_out),
      .out_en    (out_en),
      .m         (mif),
      .ovf       (ovf),
      .perr      (perr),
      .err_clr   (err_clr),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [NO-1:0] en, input logic [NB-1:0] d);
      out_en = en;
      io_out = d;
      cyc();
      out_en = '0;
   endtask

   task automatic wr_frame(input fr_t f);
      for (int k = 0; k < NO; k++) wr(NO'(1 << k), f[k]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic chk_word(input string tag, input int ch,
                           input logic [NB-1:0] d, input logic lst);
      check({tag, "_valid"}, 64'(mif.m_valid), 64'd1);
      check({tag, "_chan"}, 64'(mif.m_chan), 64'(ch));
      check({tag, "_data"}, 64'(mif.m_data), 64'(d));
      check({tag, "_last"}, 64'(mif.m_last), 64'(lst));
   endtask

   task automatic chk_idle_outs(input string tag);
      check({tag, "_valid"}, 64'(mif.m_valid), 64'd0);
      check({tag, "_data"}, 64'(mif.m_data), 64'd0);
      check({tag, "_chan"}, 64'(mif.m_chan), 64'd0);
      check({tag, "_last"}, 64'(mif.m_last), 64'd0);
      check({tag, "_ovf"}, 64'(ovf), 64'd0);
      check({tag, "_perr"}, 64'(perr), 64'd0);
      check({tag, "_fcnt"}, 64'(frame_cnt), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      fr_t a, b0, b1, b2, c, d;
      logic pat [4];
      int e;

      a[0] = 31'd5;
      a[1] = 31'h7FFF_FFFD;
      a[2] = 31'h3FFF_FFFF;
      a[3] = 31'h7FFF_FFFF;
      for (int k = 0; k < NO; k++) begin
         b0[k] = 31'(32'h100 + k);
         b1[k] = 31'(32'h200 + k);
         b2[k] = 31'(32'h300 + k);
         c[k]  = 31'(32'h4000_0000 + 32'h11 * k);
         d[k]  = 31'(32'h1234_0000 + 32'h3 * k);
      end
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

      rst = 1'b1;
      err_clr = 1'b0;
      io_out = '0;
      out_en = '0;
      mif.m_ready = 1'b0;
      cyc();
      cyc();
      chk_idle_outs("reset");
      rst = 1'b0;

      // single frame, host always ready
      mif.m_ready = 1'b1;
      wr_frame(a);
      for (int i = 0; i < NO; i++) begin
         chk_word("single", i, a[i], i == NO - 1);
         cyc();
      end
      check("single_end_valid", 64'(mif.m_valid), 64'd0);
      check("single_fcnt", 64'(frame_cnt), 64'd1);
      check("single_perr", 64'(perr), 64'd0);

      // backpressure
      do_reset();
      wr_frame(a);
      e = 0;
      for (int cy = 0; cy < 24 && e < NO; cy++) begin
         mif.m_ready = pat[cy % 4];
         chk_word("bp", e, a[e], e == NO - 1);
         if (pat[cy % 4]) e++;
         cyc();
      end
      check("bp_words", 64'(e), 64'(NO));
      check("bp_end_valid", 64'(mif.m_valid), 64'd0);

      // overflow
      do_reset();
      mif.m_ready = 1'b0;
      wr_frame(b0);
      check("ovf_after1", 64'(ovf), 64'd0);
      wr_frame(b1);
      check("ovf_after2", 64'(ovf), 64'd0);
      check("ovf_fcnt2", 64'(frame_cnt), 64'd2);
      wr_frame(b2);
      check("ovf_after3", 64'(ovf), 64'd1);
      check("ovf_fcnt3", 64'(frame_cnt), 64'd2);
      mif.m_ready = 1'b1;
      for (int i = 0; i < 2 * NO; i++) begin
         chk_word("ovf_drain", i % NO,
                  (i < NO) ? b0[i % NO] : b1[i % NO], (i % NO) == NO - 1);
         cyc();
      end
      check("ovf_end_valid", 64'(mif.m_valid), 64'd0);
      check("ovf_sticky", 64'(ovf), 64'd1);

      // protocol errors
      do_reset();
      mif.m_ready = 1'b1;
      wr(4'b0001, 31'd7);
      check("perr_first", 64'(perr), 64'd0);
      wr(4'b0001, 31'd9);
      check("perr_dup", 64'(perr), 64'd1);
      wr(4'b1010, 31'h55);
      check("perr_multi_held", 64'(perr), 64'd1);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      check("perr_clr", 64'(perr), 64'd0);
      wr(4'b0010, 31'h22);
      wr(4'b0100, 31'h44);
      check("perr_mask_valid", 64'(mif.m_valid), 64'd0);
      check("perr_mask_nodup", 64'(perr), 64'd0);
      wr(4'b1000, 31'h88);
      check("perr_mask_nodup2", 64'(perr), 64'd0);
      chk_word("perr_w0", 0, 31'd9, 1'b0);
      cyc();
      chk_word("perr_w1", 1, 31'h22, 1'b0);
      cyc();
      chk_word("perr_w2", 2, 31'h44, 1'b0);
      cyc();
      chk_word("perr_w3", 3, 31'h88, 1'b1);
      cyc();
      wr(4'b0110, 31'h1);
      check("perr_multi", 64'(perr), 64'd1);
      out_en = 4'b0011;
      err_clr = 1'b1;
      cyc();
      out_en = '0;
      err_clr = 1'b0;
      check("perr_clr_wins", 64'(perr), 64'd0);

      // back-to-back frames
      do_reset();
      mif.m_ready = 1'b1;
      wr_frame(c);
      for (int i = 0; i < 2 * NO; i++) begin
         if (i < NO) begin
            out_en = NO'(1 << i);
            io_out = d[i];
         end else begin
            out_en = '0;
         end
         chk_word("b2b", i % NO,
                  (i < NO) ? c[i % NO] : d[i % NO], (i % NO) == NO - 1);
         cyc();
      end
      out_en = '0;
      check("b2b_end_valid", 64'(mif.m_valid), 64'd0);
      check("b2b_fcnt", 64'(frame_cnt), 64'd2);

      // reset mid-frame with a buffered frame pending
      do_reset();
      mif.m_ready = 1'b0;
      wr_frame(c);
      wr(4'b0001, 31'h66);
      wr(4'b0010, 31'h77);
      rst = 1'b1;
      cyc();
      chk_idle_outs("rst_mid");
      rst = 1'b0;
      mif.m_ready = 1'b1;
      cyc();
      cyc();
      chk_idle_outs("rst_after");
      wr(4'b1000, d[3]);
      wr(4'b0100, d[2]);
      check("rst_partial_valid", 64'(mif.m_valid), 64'd0);
      wr(4'b0001, d[0]);
      wr(4'b0010, d[1]);
      for (int i = 0; i < NO; i++) begin
         chk_word("rst_new", i, d[i], i == NO - 1);
         cyc();
      end
      check("rst_end_valid", 64'(mif.m_valid), 64'd0);
      check("rst_perr", 64'(perr), 64'd0);
      check("rst_fcnt", 64'(frame_cnt), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
